// File: rtl/npu_feeder_pkg.sv
// Shared types and default sizing for the conv pixel feeder and its frame RAM.
package npu_feeder_pkg;

  localparam int DEF_IMG_W   = 32;
  localparam int DEF_IMG_H   = 32;
  localparam int DEF_K       = 3;
  localparam int ADDR_W      = $clog2(DEF_IMG_W * DEF_IMG_H);
  localparam int EXP_RESULTS = (DEF_IMG_W - DEF_K + 1) * (DEF_IMG_H - DEF_K + 1);
  localparam int RCNT_W      = $clog2(EXP_RESULTS + 1);

  typedef enum logic [2:0] {IDLE, START, GAP, STREAM, DRAIN} feeder_state_e;
  typedef enum logic [1:0] {PAT_RAM, PAT_VEDGE, PAT_CHECK, PAT_ZERO} feeder_pat_e;

  // Generated patterns are pure black/white, so one bit per pixel is enough.
  function automatic logic pat_pixel_on(feeder_pat_e p, logic right_half, logic odd_sum);
    case (p)
      PAT_VEDGE: return right_half;
      PAT_CHECK: return ~odd_sum;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/feeder_frame_ram.sv
// One-frame pixel store: 1 write port, 1 read port, registered read data (1-cycle latency).
module feeder_frame_ram #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_pixel_feeder.sv
// Frame source for the conv engine: buffers one frame, streams it row-major on go, and
// counts result beats to report completion/timeout. FEEDER_PATTERN_EN adds built-in test patterns.
module conv_pixel_feeder
  import npu_feeder_pkg::*;
#(
  parameter  int IMG_W   = DEF_IMG_W,
  parameter  int IMG_H   = DEF_IMG_H,
  parameter  int PIX_W   = 8,
  parameter  int K       = DEF_K,
  parameter  int TIMEOUT = 4096,
  localparam int AW      = $clog2(IMG_W * IMG_H),
  localparam int NRES    = (IMG_W - K + 1) * (IMG_H - K + 1),
  localparam int CW      = $clog2(NRES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             go,
`ifdef FEEDER_PATTERN_EN
  input  logic [1:0]       pattern_sel,
`endif
  output logic             busy,
  output logic             start_signal,
  output logic             pixel_valid,
  output logic [PIX_W-1:0] pixel_in,
  input  logic             result_valid,
  input  logic             done_signal,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CW-1:0]    result_cnt
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  feeder_state_e    state, state_nx;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             rd_end, rd_issue, ram_rd, last_rd, go_ok, pix_vld;
  logic [AW-1:0]    rd_addr;
  logic [PIX_W-1:0] ram_q, src_pix;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [TW-1:0]    drain_cnt;
  logic             done_ok, done_to;
  logic             unused;

  // The result count alone decides completion; done_signal is observed but never acted on.
  assign unused = done_signal;

  assign go_ok        = go & (state == IDLE);
  assign busy         = (state != IDLE);
  assign start_signal = (state == START);
  assign pixel_valid  = pix_vld;
  assign result_cnt   = cnt;

  // x/y name the next address to read; GAP issues (0,0), STREAM issues the rest.
  assign rd_issue = (state == GAP) | ((state == STREAM) & ~rd_end);
  assign last_rd  = (x == XW'(IMG_W - 1)) & (y == YW'(IMG_H - 1));
  assign rd_addr  = AW'(y) * AW'(IMG_W) + AW'(x);
  assign cnt_nx   = cnt + CW'(result_valid & busy & (cnt != CW'(NRES)));

  feeder_frame_ram #(.DEPTH(IMG_W * IMG_H), .WIDTH(PIX_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en & ~busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

`ifdef FEEDER_PATTERN_EN
  feeder_pat_e      pat_q;
  logic [PIX_W-1:0] gen_q;

  // Generated pixels are registered alongside the RAM read so both sources share timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= PAT_RAM;
      gen_q <= '0;
    end else begin
      if (go_ok)    pat_q <= feeder_pat_e'(pattern_sel);
      if (rd_issue) gen_q <= {PIX_W{pat_pixel_on(pat_q, x >= XW'(IMG_W / 2), x[0] ^ y[0])}};
    end
  end

  assign ram_rd  = rd_issue & (pat_q == PAT_RAM);
  assign src_pix = (pat_q == PAT_RAM) ? ram_q : gen_q;
`else
  assign ram_rd  = rd_issue;
  assign src_pix = ram_q;
`endif

  assign pixel_in = pix_vld ? src_pix : '0;

  always_comb begin
    state_nx = state;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      IDLE:   if (go) state_nx = START;
      START:  state_nx = GAP;
      GAP:    state_nx = STREAM;
      STREAM: if (!rd_issue) state_nx = DRAIN;
      DRAIN: begin
        // Reaching the count beats a timeout landing on the same cycle.
        if (cnt_nx == CW'(NRES)) begin
          done_ok  = 1'b1;
          state_nx = IDLE;
        end else if (drain_cnt == TW'(TIMEOUT - 1)) begin
          done_to  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      rd_end     <= 1'b0;
      pix_vld    <= 1'b0;
      cnt        <= '0;
      drain_cnt  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      pix_vld    <= rd_issue;
      frame_done <= done_ok | done_to;
      frame_err  <= done_to;
      drain_cnt  <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (go_ok) begin
        x      <= '0;
        y      <= '0;
        rd_end <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt_nx;
        if (rd_issue) begin
          if (last_rd) begin
            rd_end <= 1'b1;
          end else if (x == XW'(IMG_W - 1)) begin
            x <= '0;
            y <= y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Scoreboard bench for conv_pixel_feeder: expected pixels are queued at go, a monitor pops them
// as pixel_valid beats arrive and also plays the conv engine by returning result_valid beats.
module tb_conv_pixel_feeder;

  localparam int W       = 32;
  localparam int H       = 32;
  localparam int N       = W * H;
  localparam int K       = 3;
  localparam int NRES    = (W - K + 1) * (H - K + 1);
  localparam int TIMEOUT = 4096;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       wr_en       = 1'b0;
  logic [9:0] wr_addr     = '0;
  logic [7:0] wr_data     = '0;
  logic       go          = 1'b0;
  logic       done_signal = 1'b0;
  logic       engine_rv   = 1'b0;
  logic       manual_rv   = 1'b0;
  logic       result_valid;
  logic       busy, start_signal, pixel_valid, frame_done, frame_err;
  logic [7:0] pixel_in;
  logic [9:0] result_cnt;
`ifdef FEEDER_PATTERN_EN
  logic [1:0] pattern_sel = 2'd0;
`endif

  assign result_valid = engine_rv | manual_rv;

  conv_pixel_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .go           (go),
`ifdef FEEDER_PATTERN_EN
    .pattern_sel  (pattern_sel),
`endif
    .busy         (busy),
    .start_signal (start_signal),
    .pixel_valid  (pixel_valid),
    .pixel_in     (pixel_in),
    .result_valid (result_valid),
    .done_signal  (done_signal),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .result_cnt   (result_cnt)
  );

  always #5 clk = ~clk;

  int         errors = 0, checks = 0, cyc = 0;
  logic [7:0] mem    [N];
  logic [7:0] px_log [N];
  logic [7:0] exp_q  [$];
  int         pix_idx = 0, beats = 0, res_limit = 0, starts = 0;
  int         start_cyc = 0, last_pix_cyc = 0, cur_pat = 0;
  bit         all_beats = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame content: RAM image or the selected test pattern, by coordinates.
  function automatic logic [7:0] exp_pix(int i);
    int px = i % W;
    int py = i / W;
    case (cur_pat)
      1:       return (px < W / 2) ? 8'd0 : 8'd255;
      2:       return ((px + py) % 2 == 0) ? 8'd255 : 8'd0;
      3:       return 8'd0;
      default: return mem[i];
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor + engine model: a valid 3x3 window ends at every pixel with x>=K-1 and y>=K-1;
  // the engine answers one cycle after that pixel, up to res_limit beats (or every pixel).
  initial forever begin
    @(negedge clk);
    engine_rv = 1'b0;
    if (start_signal) begin
      pix_idx   = 0;
      beats     = 0;
      start_cyc = cyc;
      starts++;
    end
    if (pixel_valid) begin
      if (exp_q.size() == 0) chk("extra_pixel", pixel_in, -1);
      else chk("pixel", pixel_in, exp_q.pop_front());
      if (pix_idx == 0) chk("first_pixel_latency", cyc - start_cyc, 2);
      if (pix_idx < N) px_log[pix_idx] = pixel_in;
      last_pix_cyc = cyc;
      if (beats < res_limit &&
          (all_beats || ((pix_idx % W) >= K - 1 && (pix_idx / W) >= K - 1))) begin
        engine_rv = 1'b1;
        beats++;
      end
      pix_idx++;
    end else begin
      chk("pixel_in_idle_zero", pixel_in, 0);
    end
  end

  task automatic fill(input bit ramp);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_data = ramp ? 8'(i & 255) : 8'($urandom_range(0, 255));
      mem[i]  = wr_data;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input int limit, input bit all);
    res_limit = limit;
    all_beats = all;
    pix_idx   = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(exp_pix(i));
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output logic derr);
    bit got = 1'b0;
    dcyc = -1;
    derr = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got  = 1'b1;
        dcyc = cyc;
        derr = frame_err;
      end
    end
    chk("frame_done_seen", got, 1);
  endtask

  task automatic wait_pix(input int n);
    int i = 0;
    while (pix_idx < n && i < 3000) begin
      @(posedge clk);
      i++;
    end
    chk("reach_pixel", pix_idx >= n, 1);
  endtask

  initial begin
    int   dcyc;
    logic derr;
    int   s0;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", start_signal, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_in", pixel_in, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_result_cnt", result_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp frame, full result count: the final beat lands on the last STREAM cycle.
    fill(1'b1);
    start_frame(NRES, 1'b0);
    wait_done(N + 200, dcyc, derr);
    chk("t1_err", derr, 0);
    chk("t1_cnt", result_cnt, NRES);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_starts", starts, 1);
    chk("t1_done_latency", dcyc - last_pix_cyc, 2);
    chk("t1_busy_after", busy, 0);
    @(negedge clk);
    manual_rv = 1'b1;
    @(negedge clk);
    manual_rv = 1'b0;
    chk("idle_result_ignored", result_cnt, NRES);

    // One result short, done_signal asserted throughout: must still time out.
    fill(1'b0);
    done_signal = 1'b1;
    start_frame(NRES - 1, 1'b0);
    wait_done(N + TIMEOUT + 200, dcyc, derr);
    done_signal = 1'b0;
    chk("t2_err", derr, 1);
    chk("t2_timeout_latency", dcyc - (last_pix_cyc + 1), TIMEOUT);
    chk("t2_cnt", result_cnt, NRES - 1);
    chk("t2_left", exp_q.size(), 0);

    // Beat on every pixel (count saturates mid-stream); go and a write while busy are dropped.
    s0 = starts;
    start_frame(1 << 20, 1'b1);
    wait_pix(200);
    @(negedge clk);
    go      = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 10'd5;
    wr_data = ~mem[5];
    @(negedge clk);
    go    = 1'b0;
    wr_en = 1'b0;
    wait_done(N + 200, dcyc, derr);
    chk("t3_starts", starts, s0 + 1);
    chk("t3_err", derr, 0);
    chk("t3_cnt_saturated", result_cnt, NRES);
    chk("t3_done_latency", dcyc - last_pix_cyc, 2);
    chk("t3_left", exp_q.size(), 0);
    start_frame(NRES, 1'b0);
    wait_done(N + 200, dcyc, derr);
    chk("t3_rerun_err", derr, 0);
    chk("t3_rerun_left", exp_q.size(), 0);
    chk("t3_ram5_unchanged", px_log[5], mem[5]);

    // Reset mid-frame, then a clean full frame.
    fill(1'b0);
    start_frame(NRES, 1'b0);
    wait_pix(500);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_pixel_valid", pixel_valid, 0);
    chk("t4_busy", busy, 0);
    chk("t4_start", start_signal, 0);
    chk("t4_pixel_in", pixel_in, 0);
    chk("t4_cnt", result_cnt, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(NRES, 1'b0);
    wait_done(N + 200, dcyc, derr);
    chk("t4_rerun_err", derr, 0);
    chk("t4_rerun_left", exp_q.size(), 0);
    chk("t4_rerun_cnt", result_cnt, NRES);

`ifdef FEEDER_PATTERN_EN
    // pattern_sel is changed right after go to confirm it is latched.
    cur_pat     = 2;
    pattern_sel = 2'd2;
    start_frame(NRES, 1'b0);
    pattern_sel = 2'd0;
    wait_done(N + 200, dcyc, derr);
    chk("t5_px00", px_log[0], 255);
    chk("t5_px10", px_log[1], 0);
    chk("t5_px01", px_log[W], 0);
    chk("t5_left", exp_q.size(), 0);
    cur_pat     = 1;
    pattern_sel = 2'd1;
    start_frame(NRES, 1'b0);
    pattern_sel = 2'd3;
    wait_done(N + 200, dcyc, derr);
    chk("t6_x15", px_log[15], 0);
    chk("t6_x16", px_log[16], 255);
    chk("t6_left", exp_q.size(), 0);
    cur_pat     = 0;
    pattern_sel = 2'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
